// File: rtl/cpu_mem_arbiter_if.sv
// Bundle of requester handshakes and memory port A pins around cpu_mem_arbiter.
// master = arbiter side, slave = requesters/memory side.
interface cpu_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 8
);
  logic              ld_start;
  logic              ld_done;
  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_gnt;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_hold;

  logic              gpu_req;
  logic [ADDR_W-1:0] gpu_addr;
  logic              gpu_gnt;
  logic              gpu_rvalid;
  logic [DATA_W-1:0] gpu_rdata;

  logic              mem_en;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              wp_fault;

  modport master (
    input  ld_start, ld_done, ld_req, ld_addr, ld_wdata,
    output ld_gnt,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_hold,
    input  gpu_req, gpu_addr,
    output gpu_gnt, gpu_rvalid, gpu_rdata,
    output mem_en, mem_write, mem_addr, mem_wdata,
    input  mem_rdata,
    output wp_fault
  );

  modport slave (
    output ld_start, ld_done, ld_req, ld_addr, ld_wdata,
    input  ld_gnt,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_hold,
    output gpu_req, gpu_addr,
    input  gpu_gnt, gpu_rvalid, gpu_rdata,
    input  mem_en, mem_write, mem_addr, mem_wdata,
    output mem_rdata,
    input  wp_fault
  );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// Port-A arbiter for CHIP-8 memory: RUN mode round-robins CPU/sprite reads, LOAD mode gives the loader the port.
// Optional MEM_WRITE_PROTECT_EN blocks CPU writes below PROT_TOP and flags wp_fault.
module cpu_mem_arbiter #(
  parameter int unsigned           ADDR_W   = 12,
  parameter int unsigned           DATA_W   = 8,
  parameter logic [ADDR_W-1:0]     PROT_TOP = ADDR_W'('h200)
) (
  input  logic          clk,
  input  logic          reset,
  cpu_mem_arbiter_if.master bus
);

`ifdef MEM_WRITE_PROTECT_EN
  localparam logic WP_EN = 1'b1;
`else
  localparam logic WP_EN = 1'b0;
`endif

  typedef enum logic {S_RUN = 1'b0, S_LOAD = 1'b1} state_t;
  typedef enum logic [1:0] {TAG_NONE = 2'd0, TAG_CPU = 2'd1, TAG_GPU = 2'd2} tag_t;

  state_t            r_state, w_state_nxt;
  tag_t              r_tag, w_tag_nxt;
  logic              r_rr_gpu, w_rr_gpu_nxt;
  logic              r_wp_fault, w_wp_fault_nxt;
  logic [DATA_W-1:0] r_cpu_rdata, r_gpu_rdata;

  logic              w_ld_gnt, w_cpu_gnt, w_gpu_gnt;
  logic              w_wp_block;
  logic              w_mem_en, w_mem_write;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic              w_cpu_rvalid, w_gpu_rvalid;

  assign w_cpu_rvalid = (r_tag == TAG_CPU);
  assign w_gpu_rvalid = (r_tag == TAG_GPU);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tag       <= TAG_NONE;
      r_rr_gpu    <= 1'b1;
      r_wp_fault  <= 1'b0;
      r_cpu_rdata <= '0;
      r_gpu_rdata <= '0;
    end else begin
      r_tag      <= w_tag_nxt;
      r_rr_gpu   <= w_rr_gpu_nxt;
      r_wp_fault <= w_wp_fault_nxt;
      if (w_cpu_rvalid) r_cpu_rdata <= bus.mem_rdata;
      if (w_gpu_rvalid) r_gpu_rdata <= bus.mem_rdata;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ld_gnt       = 1'b0;
    w_cpu_gnt      = 1'b0;
    w_gpu_gnt      = 1'b0;
    w_mem_en       = 1'b0;
    w_mem_write    = 1'b0;
    w_mem_addr     = '0;
    w_mem_wdata    = '0;
    w_tag_nxt      = TAG_NONE;
    w_rr_gpu_nxt   = r_rr_gpu;
    w_wp_fault_nxt = r_wp_fault;

    unique case (r_state)
      S_RUN: begin
        // On a tie the CPU wins only if the sprite engine was served last.
        if (bus.cpu_req && (!bus.gpu_req || r_rr_gpu)) w_cpu_gnt = 1'b1;
        else if (bus.gpu_req)                          w_gpu_gnt = 1'b1;
        if (bus.ld_start) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_ld_gnt = bus.ld_req;
        if (bus.ld_done) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase

    w_wp_block = WP_EN && w_cpu_gnt && bus.cpu_we && (bus.cpu_addr < PROT_TOP);

    if (w_ld_gnt) begin
      w_mem_en    = 1'b1;
      w_mem_write = 1'b1;
      w_mem_addr  = bus.ld_addr;
      w_mem_wdata = bus.ld_wdata;
    end else if (w_cpu_gnt) begin
      w_mem_en    = !w_wp_block;
      w_mem_write = bus.cpu_we && !w_wp_block;
      w_mem_addr  = bus.cpu_addr;
      w_mem_wdata = bus.cpu_wdata;
      w_rr_gpu_nxt = 1'b0;
      if (!bus.cpu_we) w_tag_nxt = TAG_CPU;
    end else if (w_gpu_gnt) begin
      w_mem_en     = 1'b1;
      w_mem_addr   = bus.gpu_addr;
      w_rr_gpu_nxt = 1'b1;
      w_tag_nxt    = TAG_GPU;
    end

    if (w_wp_block)        w_wp_fault_nxt = 1'b1;
    else if (bus.ld_start) w_wp_fault_nxt = 1'b0;
  end

  assign bus.ld_gnt     = w_ld_gnt;
  assign bus.cpu_gnt    = w_cpu_gnt;
  assign bus.gpu_gnt    = w_gpu_gnt;
  assign bus.cpu_hold   = (r_state != S_RUN);
  assign bus.cpu_rvalid = w_cpu_rvalid;
  assign bus.gpu_rvalid = w_gpu_rvalid;
  assign bus.cpu_rdata  = w_cpu_rvalid ? bus.mem_rdata : r_cpu_rdata;
  assign bus.gpu_rdata  = w_gpu_rvalid ? bus.mem_rdata : r_gpu_rdata;
  assign bus.mem_en     = w_mem_en;
  assign bus.mem_write  = w_mem_write;
  assign bus.mem_addr   = w_mem_addr;
  assign bus.mem_wdata  = w_mem_wdata;
  assign bus.wp_fault   = r_wp_fault;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter with a 4096x8 synchronous memory model on port A.
module tb_cpu_mem_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  cpu_mem_arbiter_if #(.ADDR_W(12), .DATA_W(8)) bus ();

  cpu_mem_arbiter #(.ADDR_W(12), .DATA_W(8), .PROT_TOP(12'h200)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] mem [4096];
  logic [7:0] mem_q;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
      else               mem_q <= mem[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = mem_q;

  function automatic logic [7:0] img(input logic [11:0] a);
    return (a == 12'h200) ? 8'h6A : (a[7:0] ^ 8'h3C);
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ld_start = 0; bus.ld_done = 0; bus.ld_req = 0; bus.ld_addr = '0; bus.ld_wdata = '0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.gpu_req = 0; bus.gpu_addr = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [47:0] outs;
    idle();
    reset = 1'b1;
    tick(); tick();
    outs = {bus.ld_gnt, bus.cpu_gnt, bus.cpu_rvalid, bus.cpu_rdata, bus.cpu_hold,
            bus.gpu_gnt, bus.gpu_rvalid, bus.gpu_rdata, bus.mem_en, bus.mem_write,
            bus.mem_addr, bus.mem_wdata, bus.wp_fault};
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL reset_outs got=%h exp=0", outs); end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.cpu_hold !== 1'b0) begin failures++; $display("FAIL reset_hold got=%b exp=0", bus.cpu_hold); end
  endtask

  task automatic test_cpu_read();
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 12'h200;
    #1;
    checks++;
    if ({bus.cpu_gnt, bus.gpu_gnt, bus.ld_gnt, bus.mem_en, bus.mem_write, bus.mem_addr} !== {5'b10010, 12'h200}) begin
      failures++; $display("FAIL rd_issue got=%b%b%b%b%b %h exp=10010 200", bus.cpu_gnt, bus.gpu_gnt,
                           bus.ld_gnt, bus.mem_en, bus.mem_write, bus.mem_addr);
    end
    tick();
    bus.cpu_req = 0;
    checks++;
    if ({bus.cpu_rvalid, bus.gpu_rvalid, bus.cpu_rdata} !== {2'b10, 8'h6A}) begin
      failures++; $display("FAIL rd_resp got=%b%b %h exp=10 6a", bus.cpu_rvalid, bus.gpu_rvalid, bus.cpu_rdata);
    end
    tick();
    checks++;
    if ({bus.cpu_rvalid, bus.cpu_rdata} !== {1'b0, 8'h6A}) begin
      failures++; $display("FAIL rd_hold got=%b %h exp=0 6a", bus.cpu_rvalid, bus.cpu_rdata);
    end
  endtask

  task automatic test_round_robin();
    logic exp_c;
    do_reset();
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 12'h200;
    bus.gpu_req = 1; bus.gpu_addr = 12'h050;
    for (int unsigned i = 0; i < 4; i++) begin
      exp_c = (i % 2 == 0);
      #1;
      checks++;
      if ({bus.cpu_gnt, bus.gpu_gnt} !== {exp_c, !exp_c}) begin
        failures++; $display("FAIL rr_gnt%0d got=%b%b exp=%b%b", i, bus.cpu_gnt, bus.gpu_gnt, exp_c, !exp_c);
      end
      tick();
      if (i == 3) begin bus.cpu_req = 0; bus.gpu_req = 0; end
      checks++;
      if (exp_c && ({bus.cpu_rvalid, bus.gpu_rvalid, bus.cpu_rdata} !== {2'b10, 8'h6A})) begin
        failures++; $display("FAIL rr_cpu_resp%0d got=%b%b %h exp=10 6a", i, bus.cpu_rvalid, bus.gpu_rvalid, bus.cpu_rdata);
      end else if (!exp_c && ({bus.cpu_rvalid, bus.gpu_rvalid, bus.gpu_rdata} !== {2'b01, img(12'h050)})) begin
        failures++; $display("FAIL rr_gpu_resp%0d got=%b%b %h exp=01 %h", i, bus.cpu_rvalid, bus.gpu_rvalid,
                             bus.gpu_rdata, img(12'h050));
      end
    end
  endtask

  task automatic test_load();
    bus.ld_req = 1; bus.ld_addr = 12'h300; bus.ld_wdata = 8'h11;
    #1;
    checks++;
    if ({bus.ld_gnt, bus.mem_en} !== 2'b00) begin
      failures++; $display("FAIL run_ld_blocked got=%b%b exp=00", bus.ld_gnt, bus.mem_en);
    end
    bus.ld_req = 0; bus.ld_start = 1;
    tick();
    bus.ld_start = 0;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 12'h300;
    bus.ld_req = 1; bus.ld_addr = 12'h300; bus.ld_wdata = 8'h5A;
    #1;
    checks++;
    if ({bus.cpu_hold, bus.cpu_gnt, bus.ld_gnt, bus.mem_en, bus.mem_write, bus.mem_addr, bus.mem_wdata}
        !== {5'b10111, 12'h300, 8'h5A}) begin
      failures++; $display("FAIL load_write got=%b%b%b%b%b %h %h exp=10111 300 5a", bus.cpu_hold, bus.cpu_gnt,
                           bus.ld_gnt, bus.mem_en, bus.mem_write, bus.mem_addr, bus.mem_wdata);
    end
    tick();
    bus.ld_req = 0; bus.ld_done = 1;
    #1;
    checks++;
    if ({bus.cpu_hold, bus.cpu_gnt} !== 2'b10) begin
      failures++; $display("FAIL load_done_cycle got=%b%b exp=10", bus.cpu_hold, bus.cpu_gnt);
    end
    tick();
    bus.ld_done = 0;
    #1;
    checks++;
    if ({bus.cpu_hold, bus.cpu_gnt} !== 2'b01) begin
      failures++; $display("FAIL load_exit got=%b%b exp=01", bus.cpu_hold, bus.cpu_gnt);
    end
    tick();
    bus.cpu_req = 0;
    checks++;
    if ({bus.cpu_rvalid, bus.cpu_rdata} !== {1'b1, 8'h5A}) begin
      failures++; $display("FAIL load_readback got=%b %h exp=1 5a", bus.cpu_rvalid, bus.cpu_rdata);
    end
  endtask

  task automatic test_ld_done_same_cycle();
    bus.ld_done = 1;
    tick();
    bus.ld_done = 0;
    checks++;
    if (bus.cpu_hold !== 1'b0) begin failures++; $display("FAIL done_in_run got=%b exp=0", bus.cpu_hold); end
    bus.ld_start = 1; bus.ld_done = 1;
    tick();
    checks++;
    if (bus.cpu_hold !== 1'b1) begin failures++; $display("FAIL both_in_run got=%b exp=1", bus.cpu_hold); end
    bus.ld_req = 1; bus.ld_addr = 12'h301; bus.ld_wdata = 8'h77;
    #1;
    checks++;
    if ({bus.ld_gnt, bus.mem_write} !== 2'b11) begin
      failures++; $display("FAIL done_req_gnt got=%b%b exp=11", bus.ld_gnt, bus.mem_write);
    end
    tick();
    idle();
    checks++;
    if (bus.cpu_hold !== 1'b0) begin failures++; $display("FAIL both_in_load got=%b exp=0", bus.cpu_hold); end
  endtask

  task automatic test_write_protect();
    logic [7:0] exp_rd;
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 12'h010; bus.cpu_wdata = 8'hFF;
    #1;
    checks++;
`ifdef MEM_WRITE_PROTECT_EN
    if ({bus.cpu_gnt, bus.mem_en, bus.mem_write} !== 3'b100) begin
      failures++; $display("FAIL wp_issue got=%b%b%b exp=100", bus.cpu_gnt, bus.mem_en, bus.mem_write);
    end
    exp_rd = img(12'h010);
`else
    if ({bus.cpu_gnt, bus.mem_en, bus.mem_write} !== 3'b111) begin
      failures++; $display("FAIL wp_issue got=%b%b%b exp=111", bus.cpu_gnt, bus.mem_en, bus.mem_write);
    end
    exp_rd = 8'hFF;
`endif
    tick();
    bus.cpu_we = 0;
    checks++;
`ifdef MEM_WRITE_PROTECT_EN
    if ({bus.wp_fault, bus.cpu_rvalid} !== 2'b10) begin
`else
    if ({bus.wp_fault, bus.cpu_rvalid} !== 2'b00) begin
`endif
      failures++; $display("FAIL wp_fault_set got=%b%b", bus.wp_fault, bus.cpu_rvalid);
    end
    tick();
    bus.cpu_req = 0;
    checks++;
    if ({bus.cpu_rvalid, bus.cpu_rdata} !== {1'b1, exp_rd}) begin
      failures++; $display("FAIL wp_readback got=%b %h exp=1 %h", bus.cpu_rvalid, bus.cpu_rdata, exp_rd);
    end
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 12'h400; bus.cpu_wdata = 8'h99;
    tick();
    bus.cpu_we = 0;
    tick();
    bus.cpu_req = 0;
    checks++;
    if ({bus.cpu_rvalid, bus.cpu_rdata} !== {1'b1, 8'h99}) begin
      failures++; $display("FAIL open_write got=%b %h exp=1 99", bus.cpu_rvalid, bus.cpu_rdata);
    end
    bus.ld_start = 1;
    tick();
    bus.ld_start = 0; bus.ld_done = 1;
    tick();
    bus.ld_done = 0;
    checks++;
    if ({bus.wp_fault, bus.cpu_hold} !== 2'b00) begin
      failures++; $display("FAIL wp_clear got=%b%b exp=00", bus.wp_fault, bus.cpu_hold);
    end
  endtask

  task automatic test_reset_mid_load();
    bus.ld_start = 1; bus.gpu_req = 1; bus.gpu_addr = 12'h050;
    #1;
    checks++;
    if (bus.gpu_gnt !== 1'b1) begin failures++; $display("FAIL inflight_gnt got=%b exp=1", bus.gpu_gnt); end
    @(posedge clk);
    reset = 1'b1;
    idle();
    #1;
    checks++;
    if ({bus.cpu_hold, bus.gpu_rvalid, bus.cpu_rvalid, bus.gpu_rdata} !== 11'b0) begin
      failures++; $display("FAIL rst_mid_load got=%b%b%b %h exp=000 00", bus.cpu_hold, bus.gpu_rvalid,
                           bus.cpu_rvalid, bus.gpu_rdata);
    end
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({bus.cpu_hold, bus.gpu_rvalid} !== 2'b00) begin
      failures++; $display("FAIL rst_release got=%b%b exp=00", bus.cpu_hold, bus.gpu_rvalid);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    mem_q    = '0;
    for (int unsigned a = 0; a < 4096; a++) mem[a] = img(12'(a));
    test_reset();
    test_cpu_read();
    test_round_robin();
    test_load();
    test_ld_done_same_cycle();
    test_write_protect();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
